// File: rtl/pipeline_trace_buffer.sv
// rtl/pipeline_trace_buffer.sv - circular trace capture buffer with trigger/post-count freeze; optional stamps via TRACE_TIMESTAMP_EN
module pipeline_trace_buffer #(
  parameter int CH_W   = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CH*CH_W-1:0]           probe_in,
  input  logic                             probe_valid,
  input  logic                             arm,
  input  logic                             trigger,
  input  logic [$clog2(DEPTH)-1:0]         post_count,
  input  logic                             rd_req,
  output logic                             rd_valid,
  output logic [NUM_CH*CH_W-1:0]           rd_data,
  output logic [CYC_W-1:0]                 rd_ts,
  output logic                             rd_trig,
  output logic [1:0]                       state,
  output logic [$clog2(DEPTH):0]           count,
  output logic                             overflow,
  output logic [CYC_W-1:0]                 cycle_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = NUM_CH * CH_W;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t cur_state, nxt_state;

  logic [PW-1:0] wr_ptr, rd_ptr, remaining;
  logic          capture, do_read, do_clear, trig_accept, trig_bit;

  // Buffer storage: no reset, contents are meaningless until written after an arm
  logic [DW-1:0] mem_data [DEPTH];
  logic          mem_trig [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
  logic [CYC_W-1:0] mem_ts [DEPTH];
`endif

  assign state = cur_state;

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_count <= '0;
    else        cycle_count <= cycle_count + CYC_W'(1);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

  // Next-state and per-cycle control strobes; capture and read live in disjoint states
  always_comb begin
    nxt_state   = cur_state;
    capture     = 1'b0;
    do_read     = 1'b0;
    do_clear    = 1'b0;
    trig_accept = 1'b0;
    trig_bit    = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (arm) begin
          do_clear  = 1'b1;
          nxt_state = S_ARMED;
        end
      end
      S_ARMED: begin
        capture  = probe_valid;
        trig_bit = trigger;
        if (trigger) begin
          trig_accept = 1'b1;
          nxt_state   = (post_count == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        capture = probe_valid;
        // remaining is never 0 here: POST is only entered with a non-zero post_count
        if (probe_valid && remaining == PW'(1)) nxt_state = S_DONE;
      end
      S_DONE: begin
        if (arm) begin
          do_clear  = 1'b1;
          nxt_state = S_ARMED;
        end else if (rd_req && count != '0) begin
          do_read = 1'b1;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Pointers, occupancy, sticky overflow and post-trigger countdown
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      remaining <= '0;
    end else if (do_clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (count == FULL) begin
          // Full: drop the oldest entry so the buffer keeps the most recent DEPTH samples
          rd_ptr   <= rd_ptr + PW'(1);
          overflow <= 1'b1;
        end else begin
          count <= count + (PW+1)'(1);
        end
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + PW'(1);
        count  <= count - (PW+1)'(1);
      end
      if (trig_accept)
        remaining <= post_count;
      else if (capture && cur_state == S_POST)
        remaining <= remaining - PW'(1);
    end
  end

  // Sample write into the circular buffer
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_data[wr_ptr] <= probe_in;
      mem_trig[wr_ptr] <= trig_bit;
`ifdef TRACE_TIMESTAMP_EN
      mem_ts[wr_ptr]   <= cycle_count;
`endif
    end
  end

  // Registered read port; data holds its last popped value between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_trig  <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      rd_ts    <= '0;
`endif
    end else begin
      rd_valid <= do_read;
      if (do_read) begin
        rd_data <= mem_data[rd_ptr];
        rd_trig <= mem_trig[rd_ptr];
`ifdef TRACE_TIMESTAMP_EN
        rd_ts   <= mem_ts[rd_ptr];
`endif
      end
    end
  end

`ifndef TRACE_TIMESTAMP_EN
  assign rd_ts = '0;
`endif

endmodule

// File: doc/pipeline_trace_buffer.md
# pipeline_trace_buffer

Parametrised on-chip trace capture unit for the MIPS pipeline. It samples NUM_CH probe words, such as per-stage PC, instruction, ALU result and WB data, on every stage-advance strobe. Samples go into a circular buffer of DEPTH entries; each entry can carry a free-running cycle stamp. A trigger freezes the capture after a programmable post-trigger count, and the buffer is then drained oldest-first through a single-cycle read port. It sits beside the `pipeline` top and gives a silicon equivalent of the bench cycle counter and stage probes.

## Interface
- CH_W, 32, width of one probe channel
- NUM_CH, 4, number of probe channels per sample
- DEPTH, 16, buffer entries; power of two, ≥ 2
- CYC_W, 32, cycle-stamp width
- PW = $clog2(DEPTH) (localparam)

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- probe_in  in  NUM_CH*CH_W  probe words; channel k is bits [k*CH_W +: CH_W]
- probe_valid  in  1  sample strobe
- arm  in  1  start a new capture
- trigger  in  1  trigger event
- post_count  in  PW  samples to capture after the trigger sample; latched when the trigger is accepted
- rd_req  in  1  pop the oldest entry
- rd_valid  out  1  one-cycle pulse; rd_data, rd_ts and rd_trig are valid
- rd_data  out  NUM_CH*CH_W  popped probe words
- rd_ts  out  CYC_W  popped cycle stamp
- rd_trig  out  1  popped entry is the trigger sample
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- count  out  PW+1  entries held, 0..DEPTH
- overflow  out  1  sticky; set when an entry was overwritten
- cycle_count  out  CYC_W  free-running cycle counter

## Operation
- **Reset values:** all outputs are 0 and state is IDLE. Write pointer, read pointer and remaining-count are 0.
- **cycle_count:** increments on every clk while reset is high and wraps modulo 2^CYC_W.
- **Capture:** a sample is captured when probe_valid=1 and state is ARMED or POST.
  - The entry stores {probe_in, cycle_count, trig}, where trig = (state==ARMED && trigger).
  - On capture, wr_ptr advances modulo DEPTH.
  - If count==DEPTH, rd_ptr also advances, the oldest entry is lost and overflow is set. Otherwise count increments.
- **IDLE:** arm=1 moves to ARMED and clears count, pointers and overflow.
- **ARMED:** trigger=1 is accepted and remaining is loaded with post_count.
  - Next state is DONE if post_count==0, otherwise POST.
  - A trigger with probe_valid=0 is still accepted, but no entry carries trig.
- **POST:**
  - Each captured sample decrements remaining.
  - The capture that decrements remaining to 0 moves the block to DONE.
  - trigger is ignored.
- **DONE:** no capture.
  - rd_req=1 with count>0 reads mem[rd_ptr] into the output registers, pulses rd_valid, advances rd_ptr and decrements count.
  - rd_req with count==0 does nothing.
  - arm=1 moves to ARMED and clears the buffer, as from IDLE.
- **Ignored inputs:** rd_req outside DONE is ignored (rd_valid stays 0). arm in ARMED or POST is ignored.
- **Simultaneous arm and rd_req in DONE:** arm wins and no read occurs.
- **Read outputs:** rd_data, rd_ts and rd_trig hold their last popped value when rd_valid=0.

## Timing
- **Capture latency:** an entry captured at edge N is readable, at the earliest, by an rd_req sampled at the edge where state==DONE. rd_ts equals cycle_count as it was before edge N.
- **Read latency:** rd_req sampled at edge N gives rd_valid=1 and the data during cycle N..N+1. Back-to-back rd_req gives one entry per cycle.
- **state:** count and overflow are registered outputs and update at the same edge as the event that changes them.
- **Reset mid-operation:** asserting reset in any state returns the block immediately to the reset values. The buffer RAM contents are don't-care after reset.
- **Throughput:** one sample per cycle and one read per cycle. Capture and read are never concurrent.

## Configuration
- **TRACE_TIMESTAMP_EN defined:** the entry stores CYC_W stamp bits, and rd_ts returns them.
- **Not defined:** no stamp storage is synthesised and rd_ts is held at 0. cycle_count is still present and still counts.

## Test plan
All scenarios use DEPTH=8, NUM_CH=2, CH_W=32, with TRACE_TIMESTAMP_EN defined unless noted.
- **Reset:** hold reset=0 for 3 cycles, then release.
  - Required: state=0, count=0, overflow=0, rd_valid=0 and cycle_count=0.
  - cycle_count=5 after 5 edges.
- **Basic capture:**
  - Stimulus: arm; capture samples 1..3 with probe ch0=i; sample 4 with trigger and post_count=2; then samples 5..6.
  - Required: state=DONE and count=6.
  - Six rd_req give ch0 = 1..6, with rd_trig=1 only on 4 and consecutive rd_ts values; count ends at 0.
- **Wrap:**
  - Stimulus: 12 pre-trigger samples (ch0=1..12), then sample 13 with trigger and post_count=0.
  - Required: overflow=1, count=8, and reads return ch0 = 6..13.
- **Gapped strobe:** probe_valid toggles 1/0 every cycle during POST with post_count=3.
  - Required: exactly 3 post entries, and rd_ts steps by 2.
- **Reset mid-operation:** assert reset during POST.
  - Required: state=0 and count=0 immediately.
  - After re-arm, the old contents are never returned.
- **Macro off:** rebuild without TRACE_TIMESTAMP_EN and repeat the basic-capture scenario.
  - Required: identical rd_data and rd_trig, with rd_ts=0 on every read.
